// File: rtl/seg_pkg.sv
// Shared types and defaults for the segment scanner.
// The top level's optional feature is selected with the LEADING_ZERO_BLANK_EN macro.
package seg_pkg;
   typedef enum logic {GAP = 1'b0, SHOW = 1'b1} scan_state_t;

   localparam int SEG_NIB_W      = 4;
   localparam int DEF_NUM_DIGITS = 4;
   localparam int DEF_SCAN_DIV   = 50000;
endpackage

// File: rtl/scan_prescaler.sv
// Dwell counter for the scanner: counts while run is high and flags the
// final cycle of each dwell with a single-cycle last_tick.
module scan_prescaler #(
   parameter int SCAN_DIV = seg_pkg::DEF_SCAN_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic last_tick
);
   localparam int CNT_W = $clog2(SCAN_DIV);

   logic [CNT_W-1:0] cnt;

   assign last_tick = run && (cnt == CNT_W'(SCAN_DIV - 1));

   // Held at zero outside a dwell so every SHOW starts from a full count.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (!run || last_tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner feeding a seven-segment decoder.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int SCAN_DIV   = DEF_SCAN_DIV
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wr_en,
   input  logic [SEG_NIB_W*NUM_DIGITS-1:0] wr_data,
   output logic [SEG_NIB_W-1:0]           nibble,
   output logic                           nib_valid,
   output logic [NUM_DIGITS-1:0]          digit_sel
);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int DISP_W = SEG_NIB_W * NUM_DIGITS;

   scan_state_t          state_q, state_n;
   logic [IDX_W-1:0]     idx_q, idx_n;
   logic [DISP_W-1:0]    disp_q;
   logic                 last_tick;
   logic [SEG_NIB_W-1:0] nibble_n;
   logic                 nib_valid_n;
   logic [NUM_DIGITS-1:0] digit_sel_n;

`ifdef LEADING_ZERO_BLANK_EN
   // True when digit i or any more significant digit is non-zero, or i is digit 0.
   function automatic logic lead_visible(input logic [DISP_W-1:0] d,
                                         input logic [IDX_W-1:0]  i);
      logic any_nz;
      any_nz = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(i) && d[SEG_NIB_W*k +: SEG_NIB_W] != '0)
            any_nz = 1'b1;
      end
      return any_nz || (i == '0);
   endfunction
`endif

   scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
      .clk       (clk),
      .reset     (reset),
      .run       (state_q == SHOW),
      .last_tick (last_tick)
   );

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      case (state_q)
         GAP:  state_n = SHOW;
         SHOW: if (last_tick) begin
            state_n = GAP;
            idx_n   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end
         default: state_n = GAP;
      endcase

      // Outputs decode the next state so the flops always match the state register.
      digit_sel_n = '0;
      nibble_n    = nibble;
      nib_valid_n = 1'b0;
      if (state_n == SHOW) begin
         digit_sel_n = NUM_DIGITS'(1) << idx_n;
         nibble_n    = disp_q[SEG_NIB_W*idx_n +: SEG_NIB_W];
`ifdef LEADING_ZERO_BLANK_EN
         nib_valid_n = lead_visible(disp_q, idx_n);
`else
         nib_valid_n = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= GAP;
         idx_q     <= '0;
         disp_q    <= '0;
         nibble    <= '0;
         nib_valid <= 1'b0;
         digit_sel <= '0;
      end else begin
         state_q   <= state_n;
         idx_q     <= idx_n;
         if (wr_en)
            disp_q <= wr_data;
         nibble    <= nibble_n;
         nib_valid <= nib_valid_n;
         digit_sel <= digit_sel_n;
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 4-cycle dwell) with a
// frame-position reference model feeding an expected-output queue.
module tb_seg_scan_ctrl;
   localparam int N = 4;
   localparam int S = 4;
   localparam int F = N * (S + 1);

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [15:0] wr_data;
   logic [3:0]  nibble;
   logic        nib_valid;
   logic [3:0]  digit_sel;

   typedef struct packed {
      logic [3:0] sel;
      logic [3:0] nib;
      logic       vld;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          pos;
   logic [15:0] m_disp;
   logic [3:0]  m_nib;

   seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .nibble    (nibble),
      .nib_valid (nib_valid),
      .digit_sel (digit_sel)
   );

   always #5 clk = ~clk;

   // One clock edge: drive inputs, predict the outputs after the edge, then check them.
   task automatic step(input logic r, input logic we, input logic [15:0] wd, input string tag);
      exp_t e, got;
      int   dig, slot;
      logic [15:0] upper;
      reset   = r;
      wr_en   = we;
      wr_data = wd;
      if (r) begin
         pos    = F - 1;
         m_disp = '0;
         m_nib  = '0;
         e      = '0;
      end else begin
         pos  = (pos + 1) % F;
         dig  = pos / (S + 1);
         slot = pos % (S + 1);
         if (slot < S) begin
            m_nib = 4'((m_disp >> (4 * dig)) & 16'hF);
            e.sel = 4'(1 << dig);
            e.nib = m_nib;
`ifdef LEADING_ZERO_BLANK_EN
            upper = m_disp >> (4 * dig);
            e.vld = (dig == 0) || (upper != 16'h0);
`else
            upper = 16'h0;
            e.vld = 1'b1 | upper[0];
`endif
         end else begin
            e.sel = 4'b0000;
            e.nib = m_nib;
            e.vld = 1'b0;
         end
         if (we) m_disp = wd;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      got = '{sel: digit_sel, nib: nibble, vld: nib_valid};
      checks++;
      assert (got.sel === e.sel) else begin
         errors++;
         $error("FAIL %s digit_sel pos=%0d got=%b exp=%b", tag, pos, got.sel, e.sel);
      end
      checks++;
      assert (got.nib === e.nib) else begin
         errors++;
         $error("FAIL %s nibble pos=%0d got=%h exp=%h", tag, pos, got.nib, e.nib);
      end
      checks++;
      assert (got.vld === e.vld) else begin
         errors++;
         $error("FAIL %s nib_valid pos=%0d got=%b exp=%b", tag, pos, got.vld, e.vld);
      end
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      pos     = F - 1;
      m_disp  = '0;
      m_nib   = '0;

      // Reset state, then first dwell and gap.
      repeat (3) step(1'b1, 1'b0, 16'h0, "reset");
      repeat (5) step(1'b0, 1'b0, 16'h0, "first_dwell");

      // Full frames of a mixed value, including wrap to digit 0.
      step(1'b1, 1'b0, 16'h0, "reset2");
      step(1'b0, 1'b1, 16'h1A2F, "wr_1a2f");
      repeat (24) step(1'b0, 1'b0, 16'h0, "frame_1a2f");

      // Mid-dwell write on digit 0 takes effect on the next edge.
      step(1'b1, 1'b0, 16'h0, "reset3");
      step(1'b0, 1'b1, 16'h0003, "wr_0003");
      step(1'b0, 1'b0, 16'h0, "show_3");
      step(1'b0, 1'b1, 16'h0007, "wr_0007");
      repeat (7) step(1'b0, 1'b0, 16'h0, "show_7");

      // Reset with a simultaneous write in the middle of digit 2.
      while ((pos / (S + 1)) != 2 || (pos % (S + 1)) != 1)
         step(1'b0, 1'b0, 16'h0, "to_dig2");
      step(1'b1, 1'b1, 16'hFFFF, "reset_wr");
      repeat (7) step(1'b0, 1'b0, 16'h0, "restart");

      // Leading-zero handling for a value with zero upper digits, then all zero.
      step(1'b0, 1'b1, 16'h0050, "wr_0050");
      repeat (22) step(1'b0, 1'b0, 16'h0, "frame_0050");
      step(1'b0, 1'b1, 16'h0000, "wr_0000");
      repeat (22) step(1'b0, 1'b0, 16'h0, "frame_0000");

      // Write landing on digit 1's final dwell cycle shows up from digit 2 on.
      step(1'b1, 1'b0, 16'h0, "reset4");
      step(1'b0, 1'b1, 16'h1111, "wr_1111");
      while (pos != (S + 1) + S - 1)
         step(1'b0, 1'b0, 16'h0, "to_dig1_last");
      step(1'b0, 1'b1, 16'h2222, "wr_2222");
      repeat (12) step(1'b0, 1'b0, 16'h0, "after_2222");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
